// File: rtl/vga_sync_decoder.sv
// VGA 640x480@60 sync decoder: measures HSYNC/VSYNC timing, locks, emits pixel coordinates.
// Optional 8-bit saturating error counter output enabled by defining VGA_DEC_ERRCNT_EN.
module vga_sync_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        px_en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        px_in,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        px_out,
    output logic        px_valid,
    output logic        locked,
    output logic        frame_done,
    output logic        err
`ifdef VGA_DEC_ERRCNT_EN
    ,
    output logic [7:0]  err_cnt
`endif
);

    localparam int unsigned CNT_W   = 11;
    localparam int unsigned H_SYNC  = 96;
    localparam int unsigned H_BP    = 48;
    localparam int unsigned H_VIS   = 640;
    localparam int unsigned H_TOTAL = 800;
    localparam int unsigned V_SYNC  = 2;
    localparam int unsigned V_BP    = 33;
    localparam int unsigned V_VIS   = 480;
    localparam int unsigned V_TOTAL = 525;
    localparam int unsigned H_START = H_SYNC + H_BP;
    localparam int unsigned H_END   = H_START + H_VIS - 1;
    localparam int unsigned V_START = V_SYNC + V_BP;
    localparam int unsigned V_END   = V_START + V_VIS - 1;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    localparam logic [1:0] SEARCH  = 2'd0;
    localparam logic [1:0] MEASURE = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;

    logic [1:0]       state, state_nx;
    logic [CNT_W-1:0] h_cnt, v_cnt, h_cnt_nx, v_cnt_nx;
    logic             hs_q, vs_q;
    logic             frame_bad, frame_bad_nx;
    logic             err_nx, fd_nx, vis_nx;
    logic             hs_fall, vs_fall;
    logic             line_err, frame_err, sat_err, any_err;

    assign hs_fall = px_en & hs_q & ~hsync;
    assign vs_fall = px_en & vs_q & ~vsync;
    assign any_err = line_err | frame_err | sat_err;

    // Counter update and timing checks for the current strobe
    always_comb begin
        h_cnt_nx  = h_cnt;
        v_cnt_nx  = v_cnt;
        line_err  = 1'b0;
        frame_err = 1'b0;
        sat_err   = 1'b0;
        if (px_en) begin
            if (hs_fall) begin
                h_cnt_nx = '0;
                line_err = ((CNT_W+1)'(h_cnt) + (CNT_W+1)'(1)) != (CNT_W+1)'(H_TOTAL);
            end else if (h_cnt != CNT_MAX) begin
                h_cnt_nx = h_cnt + CNT_W'(1);
                sat_err  = (h_cnt_nx == CNT_MAX);
            end
            if (vs_fall) begin
                v_cnt_nx  = '0;
                frame_err = ((CNT_W+1)'(v_cnt) + (CNT_W+1)'(1)) != (CNT_W+1)'(V_TOTAL);
            end else if (hs_fall && v_cnt != CNT_MAX) begin
                v_cnt_nx = v_cnt + CNT_W'(1);
                sat_err  = sat_err | (v_cnt_nx == CNT_MAX);
            end
        end
    end

    // Lock state machine: next state and pulse outputs
    always_comb begin
        state_nx     = state;
        frame_bad_nx = frame_bad;
        err_nx       = 1'b0;
        fd_nx        = 1'b0;
        case (state)
            SEARCH: begin
                if (vs_fall) begin
                    state_nx     = MEASURE;
                    frame_bad_nx = 1'b0;
                end
            end
            MEASURE: begin
                err_nx = any_err;
                if (vs_fall) begin
                    frame_bad_nx = 1'b0;
                    if (!frame_bad && !any_err) begin
                        state_nx = LOCKED;
                        fd_nx    = 1'b1;
                    end
                end else if (any_err) begin
                    frame_bad_nx = 1'b1;
                end
            end
            LOCKED: begin
                err_nx = any_err;
                if (any_err) state_nx = SEARCH;
                else if (vs_fall) fd_nx = 1'b1;
            end
            default: state_nx = SEARCH;
        endcase
    end

    assign vis_nx = px_en && (state == LOCKED)
                 && (h_cnt_nx >= CNT_W'(H_START)) && (h_cnt_nx <= CNT_W'(H_END))
                 && (v_cnt_nx >= CNT_W'(V_START)) && (v_cnt_nx <= CNT_W'(V_END));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SEARCH;
            frame_bad <= 1'b0;
            h_cnt     <= '0;
            v_cnt     <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
        end else begin
            state     <= state_nx;
            frame_bad <= frame_bad_nx;
            h_cnt     <= h_cnt_nx;
            v_cnt     <= v_cnt_nx;
            if (px_en) begin
                hs_q <= hsync;
                vs_q <= vsync;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x          <= '0;
            y          <= '0;
            px_out     <= 1'b0;
            px_valid   <= 1'b0;
            locked     <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            px_valid   <= vis_nx;
            locked     <= (state_nx == LOCKED);
            frame_done <= fd_nx;
            err        <= err_nx;
            if (vis_nx) begin
                x      <= h_cnt_nx - CNT_W'(H_START);
                y      <= v_cnt_nx - CNT_W'(V_START);
                px_out <= px_in;
            end
        end
    end

`ifdef VGA_DEC_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_nx && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port px_en, input, 1 bit: pixel strobe; HSYNC/VSYNC/px_in are sampled only on clk edges where px_en=1.
REQ-004 SHALL have ports hsync and vsync, each input, 1 bit: sync inputs, active-low (640x480@60 polarity).
REQ-005 SHALL have port px_in, input, 1 bit: monochrome pixel level (MSB of the RED bus).
REQ-006 SHALL have ports x and y, each output, 11 bits: visible pixel coordinates of the sample in px_out.
REQ-007 SHALL have port px_out, output, 1 bit: registered copy of px_in for that sample.
REQ-008 SHALL have port px_valid, output, 1 bit: x/y/px_out hold a visible-region sample while locked.
REQ-009 SHALL have port locked, output, 1 bit: timing lock indicator.
REQ-010 SHALL have ports frame_done and err, each output, 1 bit: one-clk pulses.
REQ-011 SHALL use fixed timing constants: H_SYNC=96, H_BP=48, H_VIS=640, H_TOTAL=800; V_SYNC=2, V_BP=33, V_VIS=480, V_TOTAL=525.

Function
REQ-012 SHALL keep h_cnt (11b), counting px_en strobes since last hsync falling edge (1->0 between consecutive sampled strobes); that strobe loads h_cnt=0.
REQ-013 SHALL, on each hsync falling edge, compare old h_cnt+1 to H_TOTAL; mismatch = line error.
REQ-014 SHALL keep v_cnt (11b), incremented on every hsync falling edge, loaded to 0 on a vsync falling edge; vsync edge wins when both edges occur on the same strobe.
REQ-015 SHALL, on each vsync falling edge, compare old v_cnt+1 to V_TOTAL; mismatch = frame error.
REQ-016 SHALL saturate h_cnt and v_cnt at 2047 (no wrap); reaching 2047 = error.
REQ-017 SHALL implement FSM SEARCH, MEASURE, LOCKED; SEARCH->MEASURE on first vsync falling edge.
REQ-018 SHALL, in MEASURE, go to LOCKED at the next vsync falling edge if no error occurred during the frame; otherwise stay in MEASURE with a fresh frame.
REQ-019 SHALL, in LOCKED, go to SEARCH on any error.
REQ-020 SHALL pulse err for one clk, one cycle after the offending strobe, on any error in MEASURE or LOCKED; errors in SEARCH are ignored.
REQ-021 SHALL pulse frame_done for one clk, one cycle after each vsync falling edge processed in LOCKED (including the MEASURE->LOCKED edge).
REQ-022 SHALL assert locked exactly while state is LOCKED (registered).
REQ-023 SHALL, one clk after a px_en strobe in LOCKED with h_cnt in [144,783] and v_cnt in [35,514] (post-update values), set px_valid=1, x=h_cnt-144, y=v_cnt-35, px_out=px_in; otherwise px_valid=0 and x/y/px_out hold.
REQ-024 SHALL deassert px_valid on clks without px_en.

Reset
REQ-025 SHALL, when rst=1 at a clk edge, set state=SEARCH, h_cnt=v_cnt=0, sync history=1, and x=y=0, px_out=0, px_valid=0, locked=0, frame_done=0, err=0, regardless of px_en.
REQ-026 SHALL, on reset mid-frame, require a full SEARCH->MEASURE->LOCKED sequence before locked rises again.

Configuration
REQ-027 SHALL, with VGA_DEC_ERRCNT_EN defined, add output err_cnt (8 bits, reset 0), incremented on each err pulse, saturating at 255, cleared only by rst.
REQ-028 SHALL, without VGA_DEC_ERRCNT_EN, have no err_cnt port and identical other behaviour.

Verification
REQ-029 SHALL cover: rst, then nominal 800x525 timing with px_en every 2nd clk -> locked=1 one clk after the 2nd vsync falling edge; frame_done pulses once per frame thereafter.
REQ-030 SHALL cover: locked, strobe at h_cnt=144, v_cnt=35 with px_in=1 -> next clk px_valid=1, x=0, y=0, px_out=1; at h_cnt=783, v_cnt=514 -> x=639, y=479.
REQ-031 SHALL cover: locked, one line of 799 strobes -> err pulse, locked=0 next clk, state SEARCH; relock after two further clean vsync edges.
REQ-032 SHALL cover: frame of 524 lines during MEASURE -> err pulse, no lock; next clean frame -> locked=1.
REQ-033 SHALL cover: hsync and vsync falling on same strobe -> v_cnt=0, not 1.
REQ-034 SHALL cover: with VGA_DEC_ERRCNT_EN, 300 forced line errors -> err_cnt=255; rst mid-frame -> all outputs 0 next clk.
